// File: rtl/xosera_pkg.sv
// Shared types and TMDS control tokens for the video output path.
package xosera_pkg;

    typedef logic [11:0] rgb_t;
    typedef logic [9:0]  tmds_sym_t;

    localparam tmds_sym_t TMDS_CTL0 = 10'b1101010100;
    localparam tmds_sym_t TMDS_CTL1 = 10'b0010101011;
    localparam tmds_sym_t TMDS_CTL2 = 10'b0101010100;
    localparam tmds_sym_t TMDS_CTL3 = 10'b1010101011;

    // Control token selected by {c1, c0}
    function automatic tmds_sym_t tmds_ctl_token(input logic [1:0] ctl);
        tmds_sym_t tok;
        unique case (ctl)
            2'b00:   tok = TMDS_CTL0;
            2'b01:   tok = TMDS_CTL1;
            2'b10:   tok = TMDS_CTL2;
            default: tok = TMDS_CTL3;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/video_tmds_encode_ch.sv
// One TMDS channel: stage 1 transition-minimises the byte, stage 2 DC-balances
// against a running disparity counter or emits a control token during blanking.
module tmds_encoder_ch
    import xosera_pkg::*;
(
    input  logic       clk,
    input  logic       reset_i,
    input  logic       de_i,
    input  logic [1:0] ctl_i,
    input  logic [7:0] data_i,
    output tmds_sym_t  sym_o
);

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = popcount8(d);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Stage 1: transition-minimised word plus aligned control
    logic [8:0] qm_p1_q;
    logic       de_p1_q;
    logic [1:0] ctl_p1_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            qm_p1_q  <= '0;
            de_p1_q  <= 1'b0;
            ctl_p1_q <= 2'b00;
        end else begin
            qm_p1_q  <= tmds_qm(data_i);
            de_p1_q  <= de_i;
            ctl_p1_q <= ctl_i;
        end
    end

    // Stage 2: DC balance; cnt equals the running disparity of the emitted stream
    logic [3:0]        n1_p1, n0_p1;
    logic signed [4:0] diff_p1;
    logic signed [4:0] cnt_q, cnt_d;
    tmds_sym_t         sym_q, sym_d;
    logic              qm8;

    assign qm8     = qm_p1_q[8];
    assign n1_p1   = popcount8(qm_p1_q[7:0]);
    assign n0_p1   = 4'd8 - n1_p1;
    assign diff_p1 = $signed({1'b0, n1_p1}) - $signed({1'b0, n0_p1});

    always_comb begin
        sym_d = tmds_ctl_token(ctl_p1_q);
        cnt_d = '0;
        if (de_p1_q) begin
            if ((cnt_q == 5'sd0) || (n1_p1 == n0_p1)) begin
                sym_d = {~qm8, qm8, qm8 ? qm_p1_q[7:0] : ~qm_p1_q[7:0]};
                cnt_d = qm8 ? (cnt_q + diff_p1) : (cnt_q - diff_p1);
            end else if (((cnt_q > 5'sd0) && (n1_p1 > n0_p1)) ||
                         ((cnt_q < 5'sd0) && (n0_p1 > n1_p1))) begin
                sym_d = {1'b1, qm8, ~qm_p1_q[7:0]};
                cnt_d = cnt_q + (qm8 ? 5'sd2 : 5'sd0) - diff_p1;
            end else begin
                sym_d = {1'b0, qm8, qm_p1_q[7:0]};
                cnt_d = cnt_q + diff_p1 - (qm8 ? 5'sd0 : 5'sd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
            sym_q <= TMDS_CTL0;
        end else begin
            cnt_q <= cnt_d;
            sym_q <= sym_d;
        end
    end

    assign sym_o = sym_q;

endmodule

// File: rtl/video_tmds_encode.sv
// DVI/HDMI TMDS encoder for 12-bit RGB: nibble expansion and per-channel wiring,
// two-cycle latency from pixel to symbol.
module video_tmds_encode
    import xosera_pkg::*;
(
    input  logic      clk,
    input  logic      reset_i,
    input  logic      vsync_i,
    input  logic      hsync_i,
    input  logic      dv_de_i,
    input  rgb_t      rgb_i,
    output tmds_sym_t tmds_r_o,
    output tmds_sym_t tmds_g_o,
    output tmds_sym_t tmds_b_o
);

    logic [7:0] red8, green8, blue8;

    assign red8   = {rgb_i[11:8], rgb_i[11:8]};
    assign green8 = {rgb_i[7:4],  rgb_i[7:4]};
    assign blue8  = {rgb_i[3:0],  rgb_i[3:0]};

    // Sync rides on blue only; red and green always send token 00 in blanking
    tmds_encoder_ch u_enc_r (
        .clk     (clk),
        .reset_i (reset_i),
        .de_i    (dv_de_i),
        .ctl_i   (2'b00),
        .data_i  (red8),
        .sym_o   (tmds_r_o)
    );

    tmds_encoder_ch u_enc_g (
        .clk     (clk),
        .reset_i (reset_i),
        .de_i    (dv_de_i),
        .ctl_i   (2'b00),
        .data_i  (green8),
        .sym_o   (tmds_g_o)
    );

    tmds_encoder_ch u_enc_b (
        .clk     (clk),
        .reset_i (reset_i),
        .de_i    (dv_de_i),
        .ctl_i   ({vsync_i, hsync_i}),
        .data_i  (blue8),
        .sym_o   (tmds_b_o)
    );

endmodule

// File: tb/tb_video_tmds_encode.sv
// Directed and reference-model checks for video_tmds_encode.
module tb_video_tmds_encode;

    logic        clk;
    logic        reset_i;
    logic        vsync_i;
    logic        hsync_i;
    logic        dv_de_i;
    logic [11:0] rgb_i;
    logic [9:0]  tmds_r_o, tmds_g_o, tmds_b_o;

    int total = 0;
    int bad   = 0;

    video_tmds_encode dut (
        .clk      (clk),
        .reset_i  (reset_i),
        .vsync_i  (vsync_i),
        .hsync_i  (hsync_i),
        .dv_de_i  (dv_de_i),
        .rgb_i    (rgb_i),
        .tmds_r_o (tmds_r_o),
        .tmds_g_o (tmds_g_o),
        .tmds_b_o (tmds_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic de, input logic [11:0] rgb, input logic hs, input logic vs);
        dv_de_i = de;
        rgb_i   = rgb;
        hsync_i = hs;
        vsync_i = vs;
        step();
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cond(input string tag, input logic ok, input int obs);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=within bound", tag, obs);
        end
    endtask

    // Reference encoder in plain integer arithmetic
    task automatic model_enc(input logic [7:0] d, input logic de, input logic [1:0] ctl,
                             input int cin, output logic [9:0] sym, output int cout);
        int ones, n1q, n0q;
        logic [8:0] q;
        if (!de) begin
            case (ctl)
                2'b00:   sym = 10'b1101010100;
                2'b01:   sym = 10'b0010101011;
                2'b10:   sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
            cout = 0;
        end else begin
            ones = $countones(d);
            q    = '0;
            q[0] = d[0];
            if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
                for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
                q[8] = 1'b0;
            end else begin
                for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
                q[8] = 1'b1;
            end
            n1q = $countones(q[7:0]);
            n0q = 8 - n1q;
            if (cin == 0 || n1q == n0q) begin
                sym  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
                cout = cin + (q[8] ? (n1q - n0q) : (n0q - n1q));
            end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
                sym  = {1'b1, q[8], ~q[7:0]};
                cout = cin + (q[8] ? 2 : 0) + n0q - n1q;
            end else begin
                sym  = {1'b0, q[8], q[7:0]};
                cout = cin + n1q - n0q - (q[8] ? 0 : 2);
            end
        end
    endtask

    function automatic logic [7:0] tmds_dec(input logic [9:0] s);
        logic [7:0] q, d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    initial begin
        logic [9:0] exp_prev [3];
        logic [9:0] exp_cur  [3];
        logic [7:0] d_prev   [3];
        logic [7:0] d_cur    [3];
        logic [9:0] obs      [3];
        logic       de_prev, have_prev;
        int         mcnt [3];
        int         disp [3];
        int         ncnt;
        logic       de_r, hs_r, vs_r;
        logic [11:0] rgb_r;

        reset_i = 1'b1;
        dv_de_i = 1'b0;
        hsync_i = 1'b0;
        vsync_i = 1'b0;
        rgb_i   = '0;
        step();
        step();
        chk("rst_r", tmds_r_o, 10'h354);
        chk("rst_g", tmds_g_o, 10'h354);
        chk("rst_b", tmds_b_o, 10'h354);

        reset_i = 1'b0;
        px(1'b0, 12'h000, 1'b1, 1'b0);
        chk("lat1_b", tmds_b_o, 10'h354);
        step();
        chk("ctl_hs_b", tmds_b_o, 10'h0AB);
        chk("ctl_hs_r", tmds_r_o, 10'h354);
        chk("ctl_hs_g", tmds_g_o, 10'h354);

        // Black run from cnt=0
        px(1'b1, 12'h000, 1'b0, 1'b0);
        px(1'b1, 12'h000, 1'b0, 1'b0);
        chk("black0_b", tmds_b_o, 10'h100);
        chk("black0_r", tmds_r_o, 10'h100);
        px(1'b1, 12'h000, 1'b0, 1'b0);
        chk("black1_b", tmds_b_o, 10'h3FF);
        px(1'b0, 12'h000, 1'b0, 1'b0);
        chk("black2_b", tmds_b_o, 10'h100);

        // White pixel, then a mixed pixel, each after blanking
        px(1'b1, 12'hFFF, 1'b0, 1'b0);
        chk("blank_tok_b", tmds_b_o, 10'h354);
        px(1'b0, 12'h000, 1'b0, 1'b0);
        chk("white_r", tmds_r_o, 10'h200);
        chk("white_g", tmds_g_o, 10'h200);
        chk("white_b", tmds_b_o, 10'h200);
        px(1'b1, 12'h030, 1'b0, 1'b0);
        px(1'b0, 12'h000, 1'b0, 1'b0);
        chk("mix_g", tmds_g_o, 10'h111);
        chk("mix_b", tmds_b_o, 10'h100);

        // Blanking clears disparity
        px(1'b1, 12'h000, 1'b0, 1'b0);
        px(1'b0, 12'h000, 1'b0, 1'b1);
        chk("clr_first_b", tmds_b_o, 10'h100);
        px(1'b1, 12'h000, 1'b0, 1'b0);
        chk("vs_tok_b", tmds_b_o, 10'h154);
        chk("vs_tok_r", tmds_r_o, 10'h354);
        px(1'b1, 12'h000, 1'b0, 1'b0);
        chk("clr_second_b", tmds_b_o, 10'h100);

        // Mid-line reset
        px(1'b1, 12'h000, 1'b0, 1'b0);
        chk("pre_rst_b", tmds_b_o, 10'h3FF);
        reset_i = 1'b1;
        px(1'b1, 12'h000, 1'b0, 1'b0);
        chk("midrst_r", tmds_r_o, 10'h354);
        chk("midrst_g", tmds_g_o, 10'h354);
        chk("midrst_b", tmds_b_o, 10'h354);
        reset_i = 1'b0;
        px(1'b1, 12'h000, 1'b0, 1'b0);
        chk("postrst_flush_b", tmds_b_o, 10'h354);
        px(1'b1, 12'h000, 1'b0, 1'b0);
        chk("postrst_px_b", tmds_b_o, 10'h100);
        chk("postrst_px_g", tmds_g_o, 10'h100);

        // Random frame against the reference model
        px(1'b0, 12'h000, 1'b0, 1'b0);
        have_prev = 1'b0;
        de_prev   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mcnt[c] = 0;
            disp[c] = 0;
            exp_prev[c] = '0;
            d_prev[c]   = '0;
        end
        for (int k = 0; k < 10000; k++) begin
            de_r  = ($urandom_range(0, 99) < 85);
            hs_r  = 1'($urandom_range(0, 1));
            vs_r  = 1'($urandom_range(0, 1));
            rgb_r = 12'($urandom_range(0, 4095));
            d_cur[0] = {rgb_r[11:8], rgb_r[11:8]};
            d_cur[1] = {rgb_r[7:4],  rgb_r[7:4]};
            d_cur[2] = {rgb_r[3:0],  rgb_r[3:0]};
            for (int c = 0; c < 3; c++) begin
                model_enc(d_cur[c], de_r, (c == 2) ? {vs_r, hs_r} : 2'b00,
                          mcnt[c], exp_cur[c], ncnt);
                mcnt[c] = ncnt;
            end
            px(de_r, rgb_r, hs_r, vs_r);
            obs[0] = tmds_r_o;
            obs[1] = tmds_g_o;
            obs[2] = tmds_b_o;
            if (have_prev) begin
                for (int c = 0; c < 3; c++) begin
                    chk($sformatf("rand%0d_ch%0d", k, c), obs[c], exp_prev[c]);
                    if (de_prev) begin
                        disp[c] += 2 * $countones(obs[c]) - 10;
                        chk_cond($sformatf("disp%0d_ch%0d", k, c),
                                 (disp[c] >= -10) && (disp[c] <= 10), disp[c]);
                        chk($sformatf("dec%0d_ch%0d", k, c),
                            {2'b00, tmds_dec(obs[c])}, {2'b00, d_prev[c]});
                    end else begin
                        disp[c] = 0;
                    end
                end
            end
            have_prev = 1'b1;
            de_prev   = de_r;
            for (int c = 0; c < 3; c++) begin
                exp_prev[c] = exp_cur[c];
                d_prev[c]   = d_cur[c];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
